// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, Ctrl-word and state definitions for the ALU2 control sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_SLL = 4'h9;
  localparam logic [3:0] OP_SLA = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_SRL = 4'hC;
  localparam logic [3:0] OP_SRA = 4'hD;
  localparam logic [3:0] OP_ROR = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;

  localparam logic [5:0] CTRL_MOV = 6'h00;
  localparam logic [5:0] CTRL_ADD = 6'h12;
  localparam logic [5:0] CTRL_SUB = 6'h22;
  localparam logic [5:0] CTRL_AND = 6'h18;
  localparam logic [5:0] CTRL_OR  = 6'h14;
  localparam logic [5:0] CTRL_XOR = 6'h1C;
  localparam logic [5:0] CTRL_NOT = 6'h0C;
  localparam logic [5:0] CTRL_INC = 6'h36;
  localparam logic [5:0] CTRL_DEC = 6'h06;
  localparam logic [5:0] CTRL_SLL = 6'h01;
  localparam logic [5:0] CTRL_SLA = 6'h09;
  localparam logic [5:0] CTRL_ROL = 6'h11;
  localparam logic [5:0] CTRL_SRL = 6'h05;
  localparam logic [5:0] CTRL_SRA = 6'h0D;
  localparam logic [5:0] CTRL_ROR = 6'h15;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

endpackage

// File: rtl/alu_ctrl_enc.sv
// Combinational opcode lookup: ALU2 Ctrl word plus shift/illegal classification.
module alu_ctrl_enc
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op_code,
  output logic [5:0] ctrl,
  output logic       is_shift,
  output logic       illegal
);

  always_comb begin
    ctrl     = CTRL_MOV;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (op_code)
      OP_MOV: ctrl = CTRL_MOV;
      OP_ADD: ctrl = CTRL_ADD;
      OP_SUB: ctrl = CTRL_SUB;
      OP_AND: ctrl = CTRL_AND;
      OP_OR:  ctrl = CTRL_OR;
      OP_XOR: ctrl = CTRL_XOR;
      OP_NOT: ctrl = CTRL_NOT;
      OP_INC: ctrl = CTRL_INC;
      OP_DEC: ctrl = CTRL_DEC;
      OP_SLL: begin ctrl = CTRL_SLL; is_shift = 1'b1; end
      OP_SLA: begin ctrl = CTRL_SLA; is_shift = 1'b1; end
      OP_ROL: begin ctrl = CTRL_ROL; is_shift = 1'b1; end
      OP_SRL: begin ctrl = CTRL_SRL; is_shift = 1'b1; end
      OP_SRA: begin ctrl = CTRL_SRA; is_shift = 1'b1; end
      OP_ROR: begin ctrl = CTRL_ROR; is_shift = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU2 control sequencer: accepts an opcode by valid/ready, issues one strobe for
// simple ops and expands shifts by N into N single-bit steps fed back from the result.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [CNT_W-1:0] op_count,
  output logic [5:0]       alu_ctrl,
  output logic             alu_en,
  output logic             alu_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [5:0]       r_alu_ctrl;
  logic             r_alu_en;
  logic             r_alu_fb;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [5:0] w_ctrl;
  logic       w_is_shift;
  logic       w_illegal;
  logic       w_accept;

  alu_ctrl_enc u_enc (
    .op_code  (op_code),
    .ctrl     (w_ctrl),
    .is_shift (w_is_shift),
    .illegal  (w_illegal)
  );

  assign op_ready = (r_state == IDLE);
  assign w_accept = op_valid & op_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_alu_ctrl <= CTRL_MOV;
      r_alu_en   <= 1'b0;
      r_alu_fb   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_alu_ctrl <= CTRL_MOV;
          r_alu_en   <= 1'b0;
          r_alu_fb   <= 1'b0;
          r_busy     <= 1'b0;
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state  <= EXEC;
              r_alu_en <= 1'b1;
              r_busy   <= 1'b1;
              // A zero-length shift degenerates to a single MOV step.
              if (w_is_shift && (op_count != '0)) begin
                r_alu_ctrl <= w_ctrl;
                r_count    <= op_count;
              end else begin
                r_alu_ctrl <= w_is_shift ? CTRL_MOV : w_ctrl;
                r_count    <= CNT_ONE;
              end
            end
          end
        end
        EXEC: begin
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_state    <= IDLE;
            r_done     <= 1'b1;
            r_alu_ctrl <= CTRL_MOV;
            r_alu_en   <= 1'b0;
            r_alu_fb   <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            // Every step after the first operates on the ALU's own result.
            r_alu_fb <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_ctrl = r_alu_ctrl;
  assign alu_en   = r_alu_en;
  assign alu_fb   = r_alu_fb;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus queues expected strobe/done/err events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = 4'h0;
  logic [3:0] op_count = 4'h0;
  logic [5:0] alu_ctrl;
  logic       alu_en, alu_fb, busy, done, err;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       en;
    logic       fb;
    logic       dn;
    logic       er;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  alu_ctrl_seq #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_count (op_count),
    .alu_ctrl (alu_ctrl),
    .alu_en   (alu_en),
    .alu_fb   (alu_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected events for an op that strobes n steps with the given Ctrl word, then done.
  task automatic push_steps(input logic [5:0] ctrl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{ctrl, 1'b1, (i > 0), 1'b0, 1'b0});
    exp_q.push_back('{6'h00, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cnt);
    op_valid = 1'b1;
    op_code  = op;
    op_count = cnt;
    chk("ready_before_accept", {31'd0, op_ready}, 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Monitor: every active cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_en || done || err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: ctrl=%0h en=%0b fb=%0b done=%0b err=%0b, expected no activity",
                   alu_ctrl, alu_en, alu_fb, done, err);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event", {20'd0, alu_ctrl, alu_en, alu_fb, done, err},
              {20'd0, e.ctrl, e.en, e.fb, e.dn, e.er});
          chk("busy_vs_en", {31'd0, busy}, {31'd0, e.en});
          chk("ready_vs_en", {31'd0, op_ready}, {31'd0, ~e.en});
        end
      end else begin
        chk("idle_outputs", {24'd0, alu_ctrl, alu_fb, busy}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    // Reset and idle
    #2;
    chk("rst_outputs", {24'd0, alu_ctrl, alu_en, alu_fb}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("idle_ready", {31'd0, op_ready}, 32'd1);
    chk("idle_en", {31'd0, alu_en}, 32'd0);

    // ADD: one strobe then done
    push_steps(6'h12, 1); issue(4'h1, 4'h7); idle(3);
    // SRA by 3: fb 0,1,1 then done
    push_steps(6'h0D, 3); issue(4'hD, 4'h3); idle(5);
    // ROL by 0 behaves as MOV
    push_steps(6'h00, 1); issue(4'hB, 4'h0); idle(3);
    // Illegal opcode: err pulse only, stays ready
    exp_q.push_back('{6'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    issue(4'hF, 4'h2);
    chk("ill_ready", {31'd0, op_ready}, 32'd1);
    idle(3);
    // A few more single ops and short shifts
    push_steps(6'h22, 1); issue(4'h2, 4'h0); idle(3);
    push_steps(6'h0C, 1); issue(4'h6, 4'h0); idle(3);
    push_steps(6'h06, 1); issue(4'h8, 4'h0); idle(3);
    push_steps(6'h15, 1); issue(4'hE, 4'h1); idle(3);
    push_steps(6'h09, 2); issue(4'hA, 4'h2); idle(4);

    // Back-to-back with op_valid held high: XOR, INC, SLL by 15
    push_steps(6'h1C, 1);
    push_steps(6'h36, 1);
    push_steps(6'h01, 15);
    op_valid = 1'b1; op_code = 4'h5; op_count = 4'h0;
    idle(1);                              // XOR accepted, EXEC
    op_code = 4'h7; op_count = 4'h3;      // ignored while busy
    idle(1);                              // XOR done cycle; INC accepted at next edge
    idle(1);                              // INC EXEC
    op_code = 4'h9; op_count = 4'hF;
    idle(1);                              // INC done cycle
    idle(1);                              // SLL step 1
    for (int i = 0; i < 4; i++) begin
      op_code  = 4'(i + 2);
      op_count = 4'(i + 1);
      idle(1);
    end
    op_valid = 1'b0;
    idle(14);
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Reset during SRL by 5 at step 2: no done, no more strobes
    exp_q.push_back('{6'h05, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{6'h05, 1'b1, 1'b1, 1'b0, 1'b0});
    issue(4'hC, 4'h5);
    @(posedge clk);
    #6;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {24'd0, alu_ctrl, alu_en, alu_fb}, 32'd0);
    chk("midrst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("midrst_ready", {31'd0, op_ready}, 32'd1);
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_rst_done", {30'd0, done, alu_en}, 32'd0);
    end
    chk("final_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
